tpu_command_assembler: RTL



---
 rtl/tpu_command_assembler_pkg.sv | 23 ++
 rtl/tpu_command_fifo.sv | 40 ++++
 rtl/tpu_command_assembler.sv | 82 ++++++++
 3 files changed

// File: rtl/tpu_command_assembler_pkg.sv
// tpu_command_assembler_pkg: TPU opcodes, command lengths, command width and issue FSM states
package tpu_command_assembler_pkg;
  localparam int CMD_W = 48;
  localparam logic [7:0] OP_CLEARSCREEN = 8'h01;
  localparam logic [7:0] OP_PRINT       = 8'h02;
  localparam logic [7:0] OP_LOCATE      = 8'h03;
  localparam logic [7:0] OP_SETATTR     = 8'h04;
  localparam logic [7:0] OP_SETMASK     = 8'h05;
  localparam logic [2:0] TPU_LEN_CLEARSCREEN = 3'd1;
  localparam logic [2:0] TPU_LEN_PRINT       = 3'd2;
  localparam logic [2:0] TPU_LEN_LOCATE      = 3'd3;
  localparam logic [2:0] TPU_LEN_SETATTR     = 3'd3;
  localparam logic [2:0] TPU_LEN_SETMASK     = 3'd4;
  localparam logic [2:0] TPU_LEN_OTHER       = 3'd1;
  typedef enum logic [1:0] {S_IDLE, S_ACK, S_HOLD} issue_state_t;
  function automatic logic [2:0] cmd_len(input logic [7:0] op);
    return op == OP_CLEARSCREEN ? TPU_LEN_CLEARSCREEN :
           op == OP_PRINT       ? TPU_LEN_PRINT :
           op == OP_LOCATE      ? TPU_LEN_LOCATE :
           op == OP_SETATTR     ? TPU_LEN_SETATTR :
           op == OP_SETMASK     ? TPU_LEN_SETMASK : TPU_LEN_OTHER;
  endfunction
endpackage

// File: rtl/tpu_command_fifo.sv
// tpu_command_fifo: single-clock FIFO of assembled TPU commands; push while full is accepted only alongside a pop
module tpu_command_fifo
  import tpu_command_assembler_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [CMD_W-1:0] din,
  input  logic             pop,
  output logic [CMD_W-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);
  logic [CMD_W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  always_comb begin
    full    = count == (AW+1)'(DEPTH);
    empty   = count == '0;
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    dout    = mem[rd_ptr];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(do_push);
      rd_ptr <= rd_ptr + AW'(do_pop);
      count  <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
  always_ff @(posedge clk) if (do_push) mem[wr_ptr] <= din;
endmodule

// File: rtl/tpu_command_assembler.sv
// tpu_command_assembler: assembles host bytes into 48-bit TPU commands, buffers and issues them.
// Optional inter-byte timeout enabled with TPU_ASSEMBLER_TIMEOUT_EN.
module tpu_command_assembler
  import tpu_command_assembler_pkg::*;
#(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          rx_valid,
  input  logic [7:0]                    rx_data,
  input  logic                          busy,
  output logic                          execute,
  output logic [CMD_W-1:0]              command,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);
  logic [2:0] idx, len;
  logic [CMD_W-1:0] asm_buf, next_word, head;
  logic complete, timeout, pop, full, empty;
  issue_state_t state, state_nxt;
  // asm_buf is cleared after every command, so bytes above the last one are already zero
  always_comb begin
    len       = cmd_len(idx == '0 ? rx_data : asm_buf[7:0]);
    next_word = asm_buf | (CMD_W'(rx_data) << {idx, 3'b000});
    complete  = rx_valid && (idx + 3'd1 == len);
  end
`ifdef TPU_ASSEMBLER_TIMEOUT_EN
  logic [31:0] idle_cnt;
  assign timeout = idx != '0 && !rx_valid && idle_cnt == 32'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk) begin
    if (reset || rx_valid || timeout || idx == '0) idle_cnt <= '0;
    else idle_cnt <= idle_cnt + 32'd1;
  end
`else
  logic unused_timeout;
  assign timeout = 1'b0;
  assign unused_timeout = |32'(TIMEOUT_CYCLES);
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      idx      <= '0;
      asm_buf  <= '0;
      overflow <= 1'b0;
    end else begin
      if (rx_valid) begin
        idx     <= complete ? 3'd0 : idx + 3'd1;
        asm_buf <= complete ? '0 : next_word;
      end else if (timeout) begin
        idx     <= '0;
        asm_buf <= '0;
      end
      if (complete && full && !pop) overflow <= 1'b1;
    end
  end
  tpu_command_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (complete),
    .din   (next_word),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );
  always_ff @(posedge clk) state <= reset ? S_IDLE : state_nxt;
  // ACK is the gap cycle the TPU needs before busy becomes visible
  always_comb
    state_nxt = state == S_IDLE ? (pop ? S_ACK : S_IDLE) :
                state == S_ACK  ? S_HOLD :
                busy            ? S_HOLD : S_IDLE;
  always_comb begin
    pop     = state == S_IDLE && !empty && !busy;
    execute = state == S_ACK;
  end
  always_ff @(posedge clk) begin
    if (reset) command <= '0;
    else if (pop) command <= head;
  end
endmodule
